if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline, directly upstream of the decode stage.
- Generates sequential fetch PCs and issues one request at a time to an instruction-memory port using a valid/ready handshake.
- Holds each returned instruction in a one-entry output buffer until decode accepts it.
- Applies branch/jump redirects from decode: kills the wrong-path instruction in the buffer and discards any wrong-path fetch still in flight.

Parameters:
RESET_PC, 32'h0000_0000, first fetch address after reset; must be word-aligned.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
id_allowin  input  1  decode can accept an instruction this cycle
if_to_id_valid  output  1  output buffer holds a valid instruction for decode
if_to_id_bus  output  64  {ins[63:32], pc[31:0]}
bj_bus  input  33  {bj_wen[32], bj_pc[31:0]} redirect request from decode
to_if_valid  input  1  decode stage holds a valid instruction
inst_req_valid  output  1  fetch request valid
inst_req_ready  input  1  memory accepts request
inst_addr  output  32  fetch address, word-aligned
inst_resp_valid  input  1  memory returns data
inst_resp_ready  output  1  stage accepts returned data
inst_rdata  input  32  returned instruction word

Behaviour:
Reset and control signals
- Reset and registers: all registers reset on posedge clk while rst=1.
  - state=S_REQ, fetch_pc=RESET_PC, buf_valid=0, discard=0.
- Outputs while rst=1: if_to_id_valid=0, inst_req_valid=0, inst_resp_ready=0.
- Redirect: redirect = bj_bus[32] & to_if_valid.
  - Redirect target = {bj_pc[31:2], 2'b00}; bj_pc[1:0] is ignored.
- Holding a redirect: decode may hold bj_wen for several cycles.
  - Every cycle with redirect=1 is handled identically; the repeated redirects are idempotent.

State machine (one outstanding request maximum)
- S_REQ: inst_req_valid=1, inst_addr=fetch_pc.
  - An unaccepted request may be retargeted: fetch_pc changes on redirect, and the memory samples the address only at handshake.
  - On handshake (req_valid & req_ready): fetch_pc<=fetch_pc+4 (wraps modulo 2^32), inflight_pc<=fetch_pc, go to S_WAIT.
  - Handshake in the same cycle as a redirect: fetch_pc<=target, discard<=1, go to S_WAIT.
  - Redirect without handshake: fetch_pc<=target, stay in S_REQ.
- S_WAIT: inst_req_valid=0.
  - inst_resp_ready = discard | redirect | ~buf_valid | id_allowin.
  - On response handshake with discard=1 or redirect=1: drop the data, discard<=0, go to S_REQ.
  - On response handshake otherwise: buffer<={inst_rdata, inflight_pc}, buf_valid<=1, go to S_REQ.
  - Redirect with no response this cycle: fetch_pc<=target, discard<=1, stay in S_WAIT.

Output buffer
- if_to_id_valid = buf_valid & ~redirect. This is combinational, so a wrong-path instruction is never latched by decode.
- if_to_id_bus = buffer contents.
- Update priority, highest first:
  1. redirect: buf_valid<=0 (flush).
  2. Response loaded this cycle: buf_valid<=1.
  3. if_to_id_valid & id_allowin: buf_valid<=0.
- Simultaneous consume and fill is allowed, giving back-to-back delivery.
- Back-pressure: while the buffer is full and id_allowin=0, inst_resp_ready=0 in S_WAIT.
  - At most one prefetched request is outstanding beyond the buffer.

Latency
- With zero-wait memory (req_ready=1, response in the cycle after the request), a steady-state instruction reaches the buffer every 2 cycles.
- First if_to_id_valid occurs 2 cycles after rst deasserts.

Reset mid-operation
- In-flight requests are abandoned.
- The memory side must also be reset; any response arriving in S_REQ is not accepted (resp_ready=0 in S_REQ).

Test Plan:
1. Reset release, RESET_PC=0, req_ready=1, 1-cycle memory, id_allowin=1 -> inst_addr sequence 0x0, 0x4, 0x8; if_to_id_bus pc field 0x0, 0x4, 0x8 with matching ins; if_to_id_valid first high 2 cycles after reset.
2. id_allowin=0 for 6 cycles with buffer full -> if_to_id_valid held at 1, bus stable, inst_resp_ready=0, no further request issued after the single prefetch; on release, PCs continue with no gap or duplicate.
3. Redirect while in S_WAIT for 0x10, bj_bus={1, 0x0000_0100} -> returned 0x10 word dropped; buffer flushed; next inst_addr=0x100; next delivered pc=0x100.
4. Redirect in the same cycle as request handshake -> that response is discarded (discard=1), and the following request is to the target.
5. Redirect with bj_pc=0x0000_0203 held for 3 cycles -> a single effective fetch at 0x200; no wrong-path instruction ever has if_to_id_valid=1 during those cycles.
6. fetch_pc=0xFFFF_FFFC sequential -> next inst_addr=0x0000_0000 (wrap); rst asserted mid-S_WAIT -> next fetch at RESET_PC and buf_valid=0.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage feeding the decode stage.
//
// Issues one word-aligned fetch at a time over a valid/ready request port,
// waits for the matching response, and parks the returned instruction in a
// one-entry buffer until decode takes it. A redirect from decode flushes the
// buffer and marks any in-flight fetch as wrong-path so its data is dropped.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   id_allowin        decode can take an instruction this cycle
//   if_to_id_valid    buffer holds a right-path instruction for decode
//   if_to_id_bus      {ins[63:32], pc[31:0]}
//   bj_bus            {bj_wen, bj_pc} redirect request from decode
//   to_if_valid       decode holds a valid instruction (qualifies bj_wen)
//   inst_req_*        fetch request handshake and address
//   inst_resp_*       fetch response handshake and data
//
// state  | meaning
// S_REQ  | request for fetch_pc presented to memory
// S_WAIT | one request outstanding, waiting for its response
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_allowin,
    output logic        if_to_id_valid,
    output logic [63:0] if_to_id_bus,
    input  logic [32:0] bj_bus,
    input  logic        to_if_valid,
    output logic        inst_req_valid,
    input  logic        inst_req_ready,
    output logic [31:0] inst_addr,
    input  logic        inst_resp_valid,
    output logic        inst_resp_ready,
    input  logic [31:0] inst_rdata
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] fetch_pc;
    logic [31:0] inflight_pc;
    logic        discard;
    logic        buf_valid;
    logic [31:0] buf_pc;
    logic [31:0] buf_ins;

    logic        redirect;
    logic [31:0] target;
    logic        req_hs;
    logic        resp_hs;
    logic        load;

    // Low bits of the redirect PC are deliberately ignored.
    logic        unused_bj_lo;
    assign unused_bj_lo = &{1'b0, bj_bus[1:0]};

    assign redirect = bj_bus[32] & to_if_valid;
    assign target   = {bj_bus[31:2], 2'b00};

    assign req_hs  = inst_req_valid & inst_req_ready;
    assign resp_hs = inst_resp_valid & inst_resp_ready;

    // Data from a wrong-path fetch (marked earlier or killed this cycle) is dropped.
    assign load = resp_hs & ~discard & ~redirect;

    assign inst_addr = fetch_pc;

    // Combinational kill so decode never latches a wrong-path instruction.
    assign if_to_id_valid = ~rst & buf_valid & ~redirect;
    assign if_to_id_bus   = {buf_ins, buf_pc};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next      = state;
        inst_req_valid  = 1'b0;
        inst_resp_ready = 1'b0;
        case (state)
            S_REQ: begin
                inst_req_valid = ~rst;
                if (~rst & inst_req_ready) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                // Accept while the buffer has room, or when the data will be dropped anyway.
                inst_resp_ready = ~rst & (discard | redirect | ~buf_valid | id_allowin);
                if (inst_resp_valid & inst_resp_ready) begin
                    state_next = S_REQ;
                end
            end
            default: state_next = S_REQ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            inflight_pc <= RESET_PC;
            discard     <= 1'b0;
            buf_valid   <= 1'b0;
            buf_pc      <= 32'h0;
            buf_ins     <= 32'h0;
        end else begin
            case (state)
                S_REQ: begin
                    if (req_hs) begin
                        inflight_pc <= fetch_pc;
                        fetch_pc    <= redirect ? target : fetch_pc + 32'd4;
                        discard     <= redirect;
                    end else if (redirect) begin
                        fetch_pc <= target;
                    end
                end
                S_WAIT: begin
                    if (redirect) begin
                        fetch_pc <= target;
                    end
                    if (resp_hs) begin
                        discard <= 1'b0;
                    end else if (redirect) begin
                        discard <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (redirect) begin
                buf_valid <= 1'b0;
            end else if (load) begin
                buf_valid <= 1'b1;
                buf_pc    <= inflight_pc;
                buf_ins   <= inst_rdata;
            end else if (if_to_id_valid & id_allowin) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a behavioural memory with random latency drives the
// fetch port, and a stream model predicts the exact sequence of PCs decode
// must receive (sequential from RESET_PC, restarting at every redirect target).
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int WATCHDOG = 80;

    logic        clk;
    logic        rst;
    logic        id_allowin;
    logic        if_to_id_valid;
    logic [63:0] if_to_id_bus;
    logic [32:0] bj_bus;
    logic        to_if_valid;
    logic        inst_req_valid;
    logic        inst_req_ready;
    logic [31:0] inst_addr;
    logic        inst_resp_valid;
    logic        inst_resp_ready;
    logic [31:0] inst_rdata;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_allowin     (id_allowin),
        .if_to_id_valid (if_to_id_valid),
        .if_to_id_bus   (if_to_id_bus),
        .bj_bus         (bj_bus),
        .to_if_valid    (to_if_valid),
        .inst_req_valid (inst_req_valid),
        .inst_req_ready (inst_req_ready),
        .inst_addr      (inst_addr),
        .inst_resp_valid(inst_resp_valid),
        .inst_resp_ready(inst_resp_ready),
        .inst_rdata     (inst_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;

    // memory model
    logic        mem_pending;
    logic [31:0] mem_addr;
    int          mem_delay;
    int          lat_max;

    // stream model and logs
    logic [31:0] exp_pc;
    logic [31:0] req_q[$];
    logic [31:0] del_q[$];
    logic        req_hs_last;
    logic [31:0] last_req_addr;
    logic        prev_hold;
    logic [63:0] prev_bus;
    int          rel_cyc;
    int          first_valid;
    int          idle;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (q.size() > i) ? q[i] : 32'hDEAD_BEE1;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Sample everything at negedge: inputs and outputs are stable and are
    // exactly what the DUT sees at the following posedge.
    task automatic sample();
        logic        redir;
        logic [31:0] tgt;
        logic        req_hs;
        logic        resp_hs;
        @(negedge clk);
        redir   = bj_bus[32] & to_if_valid;
        tgt     = {bj_bus[31:2], 2'b00};
        req_hs  = inst_req_valid & inst_req_ready;
        resp_hs = inst_resp_valid & inst_resp_ready;
        req_hs_last = 1'b0;
        if (rst) begin
            chk("rst_if_to_id_valid", {63'h0, if_to_id_valid}, 64'h0);
            chk("rst_inst_req_valid", {63'h0, inst_req_valid}, 64'h0);
            chk("rst_inst_resp_ready", {63'h0, inst_resp_ready}, 64'h0);
            exp_pc      = RESET_PC;
            mem_pending = 1'b0;
            rel_cyc     = 0;
            first_valid = -1;
            prev_hold   = 1'b0;
            idle        = 0;
        end else begin
            if (req_hs) begin
                chk("one_outstanding", {63'h0, mem_pending & ~resp_hs}, 64'h0);
                chk("addr_aligned", {62'h0, inst_addr[1:0]}, 64'h0);
                req_q.push_back(inst_addr);
                req_hs_last   = 1'b1;
                last_req_addr = inst_addr;
            end
            if (redir) begin
                chk("valid_during_redirect", {63'h0, if_to_id_valid}, 64'h0);
            end
            if (prev_hold) begin
                chk("hold_valid", {63'h0, if_to_id_valid}, {63'h0, ~redir});
                chk("hold_bus", if_to_id_bus, prev_bus);
            end
            if (if_to_id_valid && id_allowin) begin
                chk("deliver_pc", {32'h0, if_to_id_bus[31:0]}, {32'h0, exp_pc});
                chk("deliver_ins", {32'h0, if_to_id_bus[63:32]}, {32'h0, mem_fn(exp_pc)});
                del_q.push_back(if_to_id_bus[31:0]);
                exp_pc = exp_pc + 32'd4;
                idle   = 0;
            end
            if (redir) begin
                exp_pc = tgt;
                idle   = 0;
            end
            if (if_to_id_valid && first_valid < 0) first_valid = rel_cyc;
            prev_hold = if_to_id_valid & ~id_allowin;
            prev_bus  = if_to_id_bus;
            rel_cyc++;
            idle++;
            if (idle > WATCHDOG) begin
                n_vec++;
                n_err++;
                $display("FAIL progress_timeout: no delivery for %0d cycles, required <= %0d", idle, WATCHDOG);
                idle = 0;
            end
            if (resp_hs) mem_pending = 1'b0;
            if (req_hs) begin
                mem_pending = 1'b1;
                mem_addr    = inst_addr;
                mem_delay   = $urandom_range(0, lat_max);
            end
        end
    endtask

    task automatic drive_mem();
        @(posedge clk);
        #1;
        if (mem_pending) begin
            if (mem_delay == 0) begin
                inst_resp_valid = 1'b1;
            end else begin
                inst_resp_valid = 1'b0;
                mem_delay--;
            end
            inst_rdata = mem_fn(mem_addr);
        end else begin
            inst_resp_valid = 1'b0;
            inst_rdata      = $urandom;
        end
    endtask

    task automatic cycle();
        sample();
        drive_mem();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        req_q.delete();
        del_q.delete();
    endtask

    task automatic redirect_for(input logic [31:0] pc, input int n);
        bj_bus      = {1'b1, pc};
        to_if_valid = 1'b1;
        repeat (n) cycle();
        bj_bus      = 33'h0;
        to_if_valid = 1'b0;
        req_q.delete();
        del_q.delete();
    endtask

    initial begin
        rst             = 1'b1;
        id_allowin      = 1'b1;
        bj_bus          = 33'h0;
        to_if_valid     = 1'b0;
        inst_req_ready  = 1'b1;
        inst_resp_valid = 1'b0;
        inst_rdata      = 32'h0;
        mem_pending     = 1'b0;
        mem_addr        = 32'h0;
        mem_delay       = 0;
        lat_max         = 0;
        exp_pc          = RESET_PC;
        prev_hold       = 1'b0;
        prev_bus        = 64'h0;
        rel_cyc         = 0;
        first_valid     = -1;
        idle            = 0;
        req_hs_last     = 1'b0;
        last_req_addr   = 32'h0;
        #1;

        // 1: reset release, zero-wait memory, decode always ready
        do_reset();
        repeat (10) cycle();
        chk("t1_first_valid_cycle", 64'(first_valid), 64'd2);
        chk("t1_req0", {32'h0, qat(req_q, 0)}, 64'h0);
        chk("t1_req1", {32'h0, qat(req_q, 1)}, 64'h4);
        chk("t1_req2", {32'h0, qat(req_q, 2)}, 64'h8);
        chk("t1_del0", {32'h0, qat(del_q, 0)}, 64'h0);
        chk("t1_del1", {32'h0, qat(del_q, 1)}, 64'h4);
        chk("t1_del2", {32'h0, qat(del_q, 2)}, 64'h8);

        // 2: back-pressure with a full buffer
        id_allowin = 1'b0;
        do_reset();
        repeat (8) cycle();
        chk("t2_req_count", 64'(req_q.size()), 64'd2);
        chk("t2_valid_held", {63'h0, if_to_id_valid}, 64'h1);
        chk("t2_bus_pc", {32'h0, if_to_id_bus[31:0]}, 64'h0);
        chk("t2_resp_ready_low", {63'h0, inst_resp_ready}, 64'h0);
        id_allowin = 1'b1;
        del_q.delete();
        repeat (10) cycle();
        chk("t2_del0", {32'h0, qat(del_q, 0)}, 64'h0);
        chk("t2_del1", {32'h0, qat(del_q, 1)}, 64'h4);
        chk("t2_del2", {32'h0, qat(del_q, 2)}, 64'h8);

        // 3: redirect while waiting on the 0x10 fetch
        do_reset();
        for (int i = 0; i < 40 && !(req_hs_last && last_req_addr == 32'h10); i++) cycle();
        chk("t3_saw_req_0x10", {63'h0, req_hs_last}, 64'h1);
        redirect_for(32'h0000_0100, 1);
        repeat (8) cycle();
        chk("t3_next_req", {32'h0, qat(req_q, 0)}, 64'h100);
        chk("t3_next_del", {32'h0, qat(del_q, 0)}, 64'h100);

        // 4: redirect in the same cycle as a request handshake
        for (int i = 0; i < 10 && !inst_req_valid; i++) cycle();
        bj_bus      = {1'b1, 32'h0000_0300};
        to_if_valid = 1'b1;
        cycle();
        chk("t4_hs_with_redirect", {63'h0, req_hs_last}, 64'h1);
        redirect_for(32'h0000_0300, 0);
        repeat (8) cycle();
        chk("t4_next_req", {32'h0, qat(req_q, 0)}, 64'h300);
        chk("t4_next_del", {32'h0, qat(del_q, 0)}, 64'h300);

        // 5: redirect held for three cycles with unaligned bj_pc
        redirect_for(32'h0000_0203, 3);
        repeat (8) cycle();
        chk("t5_req0", {32'h0, qat(req_q, 0)}, 64'h200);
        chk("t5_req1", {32'h0, qat(req_q, 1)}, 64'h204);
        chk("t5_del0", {32'h0, qat(del_q, 0)}, 64'h200);
        chk("t5_del1", {32'h0, qat(del_q, 1)}, 64'h204);

        // 6: address wrap, then reset in the middle of a wait
        redirect_for(32'hFFFF_FFFC, 1);
        repeat (8) cycle();
        chk("t6_req_wrap0", {32'h0, qat(req_q, 0)}, 64'hFFFF_FFFC);
        chk("t6_req_wrap1", {32'h0, qat(req_q, 1)}, 64'h0);
        chk("t6_del_wrap0", {32'h0, qat(del_q, 0)}, 64'hFFFF_FFFC);
        chk("t6_del_wrap1", {32'h0, qat(del_q, 1)}, 64'h0);
        for (int i = 0; i < 10 && inst_req_valid; i++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("t6_buf_cleared", {63'h0, if_to_id_valid}, 64'h0);
        req_q.delete();
        del_q.delete();
        repeat (6) cycle();
        chk("t6_req_after_rst", {32'h0, qat(req_q, 0)}, {32'h0, RESET_PC});
        chk("t6_del_after_rst", {32'h0, qat(del_q, 0)}, {32'h0, RESET_PC});

        // random traffic: latency, back-pressure, redirects, occasional reset
        lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            id_allowin     = ($urandom_range(0, 3) != 0);
            inst_req_ready = ($urandom_range(0, 9) < 7);
            rst            = ($urandom_range(0, 499) == 0);
            if (!(bj_bus[32] && $urandom_range(0, 1) == 1)) begin
                if ($urandom_range(0, 19) == 0) begin
                    if ($urandom_range(0, 3) == 0)
                        bj_bus = {1'b1, 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))};
                    else
                        bj_bus = {1'b1, 32'($urandom)};
                    to_if_valid = ($urandom_range(0, 3) != 0);
                end else begin
                    bj_bus      = {1'b0, 32'($urandom)};
                    to_if_valid = ($urandom_range(0, 1) == 1);
                end
            end
            cycle();
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
